// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the unified-memory port arbiter.
//   state_t    : arbiter FSM states
//   gnt_t      : grant-select encoding (which port wins the memory)
//   *_DEF      : default widths and starvation limit
//   CNT_W      : width of the starvation counter (holds up to 15)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory command bus and the pipeline
// stall output of the arbiter.
//   modport slave  : the arbiter's view (requests/ack in, command/ready out)
//   modport master : the surrounding pipeline + memory view
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   // data port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   // memory side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   // pipeline
   logic              pipe_stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the IF (fetch) and MEM (data)
// stages. Data has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants made while a fetch is waiting.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.slave
//            if_*  fetch request / rdata / ready pulse
//            dm_*  data request / rdata / ready pulse
//            mem_* memory command (held until mem_ack) and response
//            pipe_stall, combinational, high while any request is unserved
// All outputs except pipe_stall are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   state_t             r_state;
   logic [CNT_W-1:0]   r_starve_cnt;
   logic               r_mem_en;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;
   logic [DATA_W-1:0]  r_if_rdata;
   logic [DATA_W-1:0]  r_dm_rdata;
   logic               r_if_ready;
   logic               r_dm_ready;

   logic               w_if_elig;
   logic               w_dm_elig;
   logic               w_grant;
   gnt_t               w_gnt_sel;

   // A port whose ready is pulsing this cycle is still showing its old
   // request, so it must not be granted again on this edge.
   // NOTE: always_comb assigns every output a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      w_if_elig = bus.if_req & ~r_if_ready;
      w_dm_elig = bus.dm_req & ~r_dm_ready;
      w_grant   = 1'b0;
      w_gnt_sel = GNT_IF;
      if (w_dm_elig && (!w_if_elig || (r_starve_cnt < CNT_LIMIT))) begin
         w_grant   = 1'b1;
         w_gnt_sel = GNT_DM;
      end else if (w_if_elig) begin
         w_grant   = 1'b1;
         w_gnt_sel = GNT_IF;
      end
   end

   // NOTE: state and output registers use non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
         r_if_ready   <= 1'b0;
         r_dm_ready   <= 1'b0;
      end else begin
         // ready is a single-cycle pulse
         r_if_ready <= 1'b0;
         r_dm_ready <= 1'b0;

         case (r_state)
            IDLE: begin
               // mem_ack is ignored here: no command is outstanding
               if (w_grant) begin
                  r_mem_en <= 1'b1;
                  if (w_gnt_sel == GNT_DM) begin
                     r_state     <= BUSY_DM;
                     r_mem_we    <= bus.dm_we;
                     r_mem_addr  <= bus.dm_addr;
                     r_mem_wdata <= bus.dm_wdata;
                     // counts only data grants that made a fetch wait
                     if (!bus.if_req)
                        r_starve_cnt <= '0;
                     else if (r_starve_cnt != CNT_SAT)
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                  end else begin
                     r_state      <= BUSY_IF;
                     r_mem_we     <= 1'b0;
                     r_mem_addr   <= bus.if_addr;
                     r_mem_wdata  <= '0;
                     r_starve_cnt <= '0;
                  end
               end
            end

            BUSY_IF: begin
               if (bus.mem_ack) begin
                  r_if_rdata <= bus.mem_rdata;
                  r_if_ready <= 1'b1;
                  r_mem_en   <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_state    <= IDLE;
               end
            end

            BUSY_DM: begin
               if (bus.mem_ack) begin
                  // stores leave the load-data register untouched
                  if (!r_mem_we)
                     r_dm_rdata <= bus.mem_rdata;
                  r_dm_ready <= 1'b1;
                  r_mem_en   <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_state    <= IDLE;
               end
            end

            default: begin
               r_state  <= IDLE;
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en     = r_mem_en;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.if_rdata   = r_if_rdata;
   assign bus.if_ready   = r_if_ready;
   assign bus.dm_rdata   = r_dm_rdata;
   assign bus.dm_ready   = r_dm_ready;

   // stall releases in the ready cycle itself so the pipeline advances then
   assign bus.pipe_stall = (bus.if_req & ~r_if_ready) | (bus.dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the fetch and data ports plus a behavioural memory, and compares the
// arbiter's outputs every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int STARVE = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .STARVE_MAX(STARVE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // behavioural memory, word-indexed by addr[9:2]
   logic [31:0] mem [256];

   // requester state
   bit          if_pend, dm_pend, dm_w;
   logic [31:0] if_a, dm_a, dm_d;
   bit          auto_if, auto_dm, if_gap, chaos, force_ack, rst_req;
   int          p_req     = 40;
   int          wait_mode = 0;

   // reference model: expected register outputs for the current cycle
   bit          e_mem_en, e_mem_we, e_if_ready, e_dm_ready;
   logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;
   int          busy_port;   // 0 none, 1 fetch, 2 data
   int          wait_left;
   int          starve;
   bit          prev_en;
   string       glog;

   function automatic int idx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   function automatic logic [31:0] raddr();
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      return {22'd0, w, 2'b00};
   endfunction

   function automatic int pick_wait();
      return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
   endfunction

   task automatic step();
      bit if_el, dm_el, n_ifr, n_dmr;
      @(negedge clk);
      // registered outputs of this cycle
      check("mem_en",    bus.mem_en,    e_mem_en);
      check("mem_we",    bus.mem_we,    e_mem_we);
      check("mem_addr",  bus.mem_addr,  e_mem_addr);
      check("mem_wdata", bus.mem_wdata, e_mem_wdata);
      check("if_ready",  bus.if_ready,  e_if_ready);
      check("dm_ready",  bus.dm_ready,  e_dm_ready);
      check("if_rdata",  bus.if_rdata,  e_if_rdata);
      check("dm_rdata",  bus.dm_rdata,  e_dm_rdata);
      check("starve",    dut.r_starve_cnt, starve);
      if (bus.mem_en && !prev_en)
         glog = {glog, (if_pend && bus.mem_addr == if_a) ? "I" : "D"};
      prev_en = bus.mem_en;

      // requesters: drop on ready, optionally issue a new request
      if (e_if_ready) if_pend = 0;
      if (e_dm_ready) dm_pend = 0;
      if (chaos && busy_port == 1 && $urandom_range(0, 15) == 0) if_pend = 0;
      if (chaos && busy_port == 2 && $urandom_range(0, 15) == 0) dm_pend = 0;
      if (auto_if && !if_pend && busy_port != 1 && $urandom_range(0, 99) < p_req) begin
         if_pend = 1;
         if_a    = raddr();
      end
      if (auto_dm && !dm_pend && busy_port != 2 && $urandom_range(0, 99) < p_req) begin
         dm_pend = 1;
         dm_w    = 1'($urandom_range(0, 1));
         dm_a    = raddr();
         dm_d    = $urandom;
      end
      reset        = rst_req;
      bus.if_req   = if_pend && !(if_gap && e_dm_ready);
      bus.if_addr  = if_a;
      bus.dm_req   = dm_pend;
      bus.dm_we    = dm_w;
      bus.dm_addr  = dm_a;
      bus.dm_wdata = dm_d;

      // memory responder
      if (e_mem_en) begin
         if (wait_left == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[idx(bus.mem_addr)];
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            wait_left--;
         end
      end else begin
         bus.mem_ack   = force_ack || (chaos && $urandom_range(0, 3) == 0);
         bus.mem_rdata = $urandom;
      end

      #1;
      check("pipe_stall", bus.pipe_stall,
            (bus.if_req && !e_if_ready) || (bus.dm_req && !e_dm_ready));

      // advance the model across the coming edge
      if (reset) begin
         e_mem_en = 0; e_mem_we = 0; e_if_ready = 0; e_dm_ready = 0;
         e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
         busy_port = 0; starve = 0;
      end else begin
         n_ifr = 0;
         n_dmr = 0;
         if (busy_port != 0) begin
            if (bus.mem_ack) begin
               if (busy_port == 1) begin
                  e_if_rdata = mem[idx(e_mem_addr)];
                  n_ifr      = 1;
               end else begin
                  if (e_mem_we) mem[idx(e_mem_addr)] = e_mem_wdata;
                  else          e_dm_rdata = mem[idx(e_mem_addr)];
                  n_dmr = 1;
               end
               e_mem_en  = 0;
               e_mem_we  = 0;
               busy_port = 0;
            end
         end else begin
            if_el = bus.if_req && !e_if_ready;
            dm_el = bus.dm_req && !e_dm_ready;
            if (dm_el && (!if_el || starve < STARVE)) begin
               busy_port   = 2;
               e_mem_en    = 1;
               e_mem_we    = bus.dm_we;
               e_mem_addr  = bus.dm_addr;
               e_mem_wdata = bus.dm_wdata;
               starve      = bus.if_req ? ((starve < 15) ? starve + 1 : 15) : 0;
               wait_left   = pick_wait();
            end else if (if_el) begin
               busy_port   = 1;
               e_mem_en    = 1;
               e_mem_we    = 0;
               e_mem_addr  = bus.if_addr;
               e_mem_wdata = '0;
               starve      = 0;
               wait_left   = pick_wait();
            end
         end
         e_if_ready = n_ifr;
         e_dm_ready = n_dmr;
      end
   endtask

   task automatic drain(input string tag);
      bit quiet = 0;
      for (int i = 0; i < 200 && !quiet; i++) begin
         step();
         quiet = !if_pend && !dm_pend && busy_port == 0 && !e_if_ready && !e_dm_ready;
      end
      check({tag, "_drain_timeout"}, quiet, 1'b1);
   endtask

   initial begin
      int lat, en_cnt, rdy_cnt, dm_rdy_i, if_go_i;
      logic [31:0] got;
      bit done;

      bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // reset
      rst_req = 1;
      repeat (3) step();
      rst_req = 0;
      step();

      // single fetch, zero wait states
      mem[idx(32'h40)] = 32'h8C22_0004;
      wait_mode = 0;
      if_pend = 1; if_a = 32'h40;
      lat = -1; en_cnt = 0; got = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.mem_en) en_cnt++;
         if (bus.if_ready && lat < 0) begin lat = i; got = bus.if_rdata; end
      end
      check("fetch_latency", lat, 2);
      check("fetch_en_cycles", en_cnt, 1);
      check("fetch_rdata", got, 32'h8C22_0004);

      // store with 3 wait states
      wait_mode = 3;
      dm_pend = 1; dm_w = 1; dm_a = 32'h100; dm_d = 32'hDEAD_BEEF;
      en_cnt = 0; rdy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.mem_en) en_cnt++;
         if (bus.dm_ready) rdy_cnt++;
      end
      check("store_en_cycles", en_cnt, 4);
      check("store_ready_pulses", rdy_cnt, 1);
      check("store_rdata_kept", bus.dm_rdata, 32'h0);

      // collision: data first, fetch the cycle after dm_ready
      wait_mode = 0;
      glog = "";
      dm_pend = 1; dm_w = 0; dm_a = 32'h200; dm_d = '0;
      if_pend = 1; if_a = 32'h44;
      dm_rdy_i = -1; if_go_i = -1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.dm_ready && dm_rdy_i < 0) dm_rdy_i = i;
         if (bus.mem_en && bus.mem_addr == 32'h44 && if_go_i < 0) if_go_i = i;
      end
      check("collide_order", glog == "DI", 1'b1);
      check("collide_if_gap", if_go_i - dm_rdy_i, 1);

      // starvation guard: fetch withdrawn only in dm_ready cycles so data
      // keeps winning until the counter forces a fetch grant
      glog = "";
      if_gap = 1; auto_dm = 1; p_req = 100;
      if_pend = 1; if_a = 32'h1000_0040;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         step();
         done = (glog.len() >= 5);
      end
      check("starve_order", glog == "DDDDI", 1'b1);
      check("starve_cleared", dut.r_starve_cnt, 0);
      if_gap = 0; auto_dm = 0; p_req = 40;
      drain("starve");

      // reset in the middle of a data transaction
      wait_mode = 20;
      dm_pend = 1; dm_w = 0; dm_a = 32'h80;
      repeat (3) step();
      check("rst_mid_busy", bus.mem_en, 1'b1);
      rst_req = 1; dm_pend = 0;
      step();
      rst_req = 0; force_ack = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_no_en", bus.mem_en, 1'b0);
         check("rst_no_ready", bus.dm_ready, 1'b0);
         check("rst_idle", dut.r_state == IDLE, 1'b1);
      end

      // spurious ack in IDLE with no requests
      for (int i = 0; i < 4; i++) begin
         step();
         check("spur_if_ready", bus.if_ready, 1'b0);
         check("spur_dm_ready", bus.dm_ready, 1'b0);
      end
      force_ack = 0;

      // randomized traffic
      wait_mode = -1; auto_if = 1; auto_dm = 1; chaos = 1;
      repeat (3000) step();
      auto_if = 0; auto_dm = 0; chaos = 0;
      drain("random");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
